// File: rtl/cci_mem_responder_pkg.sv
// cci_mem_responder_pkg
// Shared types and default sizes for the CCI-P line responder.
// Holds the line address, data and tag types, the request structs of the two
// request channels, and the arbiter channel select enum.
package cci_mem_responder_pkg;

    localparam int LINE_ADDR_W       = 8;
    localparam int LINE_DATA_W       = 512;
    localparam int MDATA_W           = 16;
    localparam int REQ_FIFO_DEPTH    = 8;
    localparam int REQ_ALMFULL_SLACK = 2;

    typedef logic [LINE_ADDR_W-1:0] t_line_addr;
    typedef logic [LINE_DATA_W-1:0] t_line_data;
    typedef logic [MDATA_W-1:0]     t_mdata;

    typedef struct packed {
        t_line_addr addr;
        t_mdata     mdata;
    } t_rd_req;

    typedef struct packed {
        t_line_addr addr;
        t_mdata     mdata;
        t_line_data data;
    } t_wr_req;

    typedef enum logic {
        ARB_RD = 1'b0,
        ARB_WR = 1'b1
    } t_arb_sel;

endpackage

// File: rtl/cci_mem_responder_if.sv
// cci_mem_responder_if
// Request/response bundle between an AFU-side initiator (master) and the
// host stand-in responder (slave).
//   c0_req_*  : read-line requests       c0_rsp_* : read responses
//   c1_req_*  : write-line requests      c1_rsp_* : write acks
//   c0/c1_almfull : per-channel back-pressure hints from the responder
interface cci_mem_responder_if
    import cci_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = LINE_ADDR_W,
    parameter int DATA_WIDTH  = LINE_DATA_W,
    parameter int MDATA_WIDTH = MDATA_W
) ();

    logic                   c0_req_valid;
    logic [ADDR_WIDTH-1:0]  c0_req_addr;
    logic [MDATA_WIDTH-1:0] c0_req_mdata;
    logic                   c0_almfull;
    logic                   c1_req_valid;
    logic [ADDR_WIDTH-1:0]  c1_req_addr;
    logic [MDATA_WIDTH-1:0] c1_req_mdata;
    logic [DATA_WIDTH-1:0]  c1_req_data;
    logic                   c1_almfull;
    logic                   c0_rsp_valid;
    logic [MDATA_WIDTH-1:0] c0_rsp_mdata;
    logic [DATA_WIDTH-1:0]  c0_rsp_data;
    logic                   c1_rsp_valid;
    logic [MDATA_WIDTH-1:0] c1_rsp_mdata;

    modport master (
        output c0_req_valid, c0_req_addr, c0_req_mdata,
        output c1_req_valid, c1_req_addr, c1_req_mdata, c1_req_data,
        input  c0_almfull, c1_almfull,
        input  c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
        input  c1_rsp_valid, c1_rsp_mdata
    );

    modport slave (
        input  c0_req_valid, c0_req_addr, c0_req_mdata,
        input  c1_req_valid, c1_req_addr, c1_req_mdata, c1_req_data,
        output c0_almfull, c1_almfull,
        output c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
        output c1_rsp_valid, c1_rsp_mdata
    );

endinterface

// File: rtl/cci_req_fifo.sv
// cci_req_fifo
// Synchronous request FIFO with occupancy count. Head entry is presented
// combinationally on rdata. The owner guarantees push only when not full or
// when popping in the same cycle, and pop only when not empty.
//   clk, reset : clock, synchronous active-high reset
//   push/wdata : enqueue
//   pop/rdata  : dequeue / current head
//   count, empty, full : occupancy status
module cci_req_fifo
    import cci_mem_responder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = REQ_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == CNT_ZERO);
    assign full  = (count_r == CNT_FULL);

    // Entry storage; contents need no reset because the pointers qualify them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cci_mem_responder.sv
// cci_mem_responder
// Host stand-in for the simplified CCI-P line protocol. Buffers c0 reads and
// c1 writes in per-channel FIFOs, services one per cycle against a local
// single-port line memory with round-robin arbitration, and returns c0 read
// responses (2 cycles after service) and c1 write acks (1 cycle after).
//   clk, reset   : clock, synchronous active-high reset
//   bus          : request/response bundle (slave side)
//   init_*       : backdoor preload; stalls the arbiter for that cycle
//   overflow_err : sticky, a request arrived while its FIFO was full
module cci_mem_responder
    import cci_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH    = LINE_ADDR_W,
    parameter int DATA_WIDTH    = LINE_DATA_W,
    parameter int MDATA_WIDTH   = MDATA_W,
    parameter int FIFO_DEPTH    = REQ_FIFO_DEPTH,
    parameter int ALMFULL_SLACK = REQ_ALMFULL_SLACK
) (
    input  logic                  clk,
    input  logic                  reset,
    cci_mem_responder_if.slave    bus,
    input  logic                  init_en,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic [DATA_WIDTH-1:0] init_data,
    output logic                  overflow_err
);

    localparam int RD_W      = ADDR_WIDTH + MDATA_WIDTH;
    localparam int WR_W      = RD_W + DATA_WIDTH;
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int MEM_LINES = 1 << ADDR_WIDTH;
    localparam logic [CNT_W-1:0] ALMFULL_LVL = CNT_W'(FIFO_DEPTH - ALMFULL_SLACK);

    logic             rd_push_s, rd_pop_s, rd_empty_s, rd_full_s;
    logic             wr_push_s, wr_pop_s, wr_empty_s, wr_full_s;
    logic [CNT_W-1:0] rd_count_s, wr_count_s;
    logic [RD_W-1:0]  rd_head_s;
    logic [WR_W-1:0]  wr_head_s;

    logic [ADDR_WIDTH-1:0]  rd_addr_s, wr_addr_s;
    logic [MDATA_WIDTH-1:0] rd_mdata_s, wr_mdata_s;
    logic [DATA_WIDTH-1:0]  wr_data_s;

    t_arb_sel               arb_ptr_r;
    logic                   rd_stage_vld_r;
    logic [MDATA_WIDTH-1:0] rd_stage_mdata_r;
    logic [DATA_WIDTH-1:0]  rd_data_r;
    logic [DATA_WIDTH-1:0]  mem_r [MEM_LINES];

    // A full FIFO still accepts when it pops in the same cycle.
    assign rd_push_s = bus.c0_req_valid && (!rd_full_s || rd_pop_s);
    assign wr_push_s = bus.c1_req_valid && (!wr_full_s || wr_pop_s);

    assign bus.c0_almfull = (rd_count_s >= ALMFULL_LVL);
    assign bus.c1_almfull = (wr_count_s >= ALMFULL_LVL);

    assign rd_addr_s  = rd_head_s[MDATA_WIDTH +: ADDR_WIDTH];
    assign rd_mdata_s = rd_head_s[0 +: MDATA_WIDTH];
    assign wr_addr_s  = wr_head_s[DATA_WIDTH + MDATA_WIDTH +: ADDR_WIDTH];
    assign wr_mdata_s = wr_head_s[DATA_WIDTH +: MDATA_WIDTH];
    assign wr_data_s  = wr_head_s[0 +: DATA_WIDTH];

    cci_req_fifo #(.WIDTH(RD_W), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rd_push_s),
        .pop   (rd_pop_s),
        .wdata ({bus.c0_req_addr, bus.c0_req_mdata}),
        .rdata (rd_head_s),
        .count (rd_count_s),
        .empty (rd_empty_s),
        .full  (rd_full_s)
    );

    cci_req_fifo #(.WIDTH(WR_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_push_s),
        .pop   (wr_pop_s),
        .wdata ({bus.c1_req_addr, bus.c1_req_mdata, bus.c1_req_data}),
        .rdata (wr_head_s),
        .count (wr_count_s),
        .empty (wr_empty_s),
        .full  (wr_full_s)
    );

    // Arbiter: preload owns the memory port; otherwise round robin between non-empty FIFOs.
    always_comb begin
        rd_pop_s = 1'b0;
        wr_pop_s = 1'b0;
        if (reset || init_en) begin
            rd_pop_s = 1'b0;
            wr_pop_s = 1'b0;
        end else if (!rd_empty_s && !wr_empty_s) begin
            rd_pop_s = (arb_ptr_r == ARB_RD);
            wr_pop_s = (arb_ptr_r == ARB_WR);
        end else if (!rd_empty_s) begin
            rd_pop_s = 1'b1;
        end else if (!wr_empty_s) begin
            wr_pop_s = 1'b1;
        end else begin
            rd_pop_s = 1'b0;
            wr_pop_s = 1'b0;
        end
    end

    // Line memory: single port, one write or one read per cycle; contents survive reset.
    always_ff @(posedge clk) begin
        if (init_en) begin
            mem_r[init_addr] <= init_data;
        end else if (wr_pop_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
        if (rd_pop_s) begin
            rd_data_r <= mem_r[rd_addr_s];
        end
    end

    // Response pipelines, arbiter pointer and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            arb_ptr_r        <= ARB_RD;
            rd_stage_vld_r   <= 1'b0;
            rd_stage_mdata_r <= {MDATA_WIDTH{1'b0}};
            bus.c0_rsp_valid <= 1'b0;
            bus.c0_rsp_mdata <= {MDATA_WIDTH{1'b0}};
            bus.c0_rsp_data  <= {DATA_WIDTH{1'b0}};
            bus.c1_rsp_valid <= 1'b0;
            bus.c1_rsp_mdata <= {MDATA_WIDTH{1'b0}};
            overflow_err     <= 1'b0;
        end else begin
            if (rd_pop_s) begin
                arb_ptr_r <= ARB_WR;
            end else if (wr_pop_s) begin
                arb_ptr_r <= ARB_RD;
            end

            rd_stage_vld_r <= rd_pop_s;
            if (rd_pop_s) begin
                rd_stage_mdata_r <= rd_mdata_s;
            end

            bus.c0_rsp_valid <= rd_stage_vld_r;
            if (rd_stage_vld_r) begin
                bus.c0_rsp_mdata <= rd_stage_mdata_r;
                bus.c0_rsp_data  <= rd_data_r;
            end

            bus.c1_rsp_valid <= wr_pop_s;
            if (wr_pop_s) begin
                bus.c1_rsp_mdata <= wr_mdata_s;
            end

            if ((bus.c0_req_valid && rd_full_s && !rd_pop_s) ||
                (bus.c1_req_valid && wr_full_s && !wr_pop_s)) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cci_mem_responder.sv
module tb_cci_mem_responder;
    import cci_mem_responder_pkg::*;

    localparam int AW = 8;
    localparam int DW = 512;
    localparam int MW = 16;

    typedef struct packed {
        t_mdata     mdata;
        t_line_data data;
    } t_rd_exp;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_en;
    t_line_addr    init_addr;
    t_line_data    init_data;
    logic          overflow_err;

    int checks   = 0;
    int failures = 0;
    int c0_rsp_cnt = 0;
    int rsp_base;

    t_rd_exp    rd_q [$];
    t_mdata     wr_q [$];
    t_line_data mdl  [256];
    t_rd_exp    mon_rd;
    t_mdata     mon_wr;

    cci_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MDATA_WIDTH(MW)) bus_if ();

    cci_mem_responder dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_if),
        .init_en      (init_en),
        .init_addr    (init_addr),
        .init_data    (init_data),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every response must match the oldest expectation of its channel.
    always @(negedge clk) begin
        if (!reset && bus_if.c0_rsp_valid) begin
            c0_rsp_cnt++;
            checks++;
            assert (rd_q.size() > 0) else begin
                failures++;
                $error("FAIL c0_unexpected observed=mdata %h expected=no response", bus_if.c0_rsp_mdata);
            end
            if (rd_q.size() > 0) begin
                mon_rd = rd_q.pop_front();
                checks++;
                assert (bus_if.c0_rsp_mdata === mon_rd.mdata) else begin
                    failures++;
                    $error("FAIL c0_mdata observed=%h expected=%h", bus_if.c0_rsp_mdata, mon_rd.mdata);
                end
                checks++;
                assert (bus_if.c0_rsp_data === mon_rd.data) else begin
                    failures++;
                    $error("FAIL c0_data observed=%h expected=%h", bus_if.c0_rsp_data, mon_rd.data);
                end
            end
        end
        if (!reset && bus_if.c1_rsp_valid) begin
            checks++;
            assert (wr_q.size() > 0) else begin
                failures++;
                $error("FAIL c1_unexpected observed=mdata %h expected=no response", bus_if.c1_rsp_mdata);
            end
            if (wr_q.size() > 0) begin
                mon_wr = wr_q.pop_front();
                checks++;
                assert (bus_if.c1_rsp_mdata === mon_wr) else begin
                    failures++;
                    $error("FAIL c1_mdata observed=%h expected=%h", bus_if.c1_rsp_mdata, mon_wr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkb(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic t_line_data pat(int i);
        return {16{32'hC0DE_0000 | 32'(i)}};
    endfunction

    task automatic set_rd(logic v, t_line_addr a, t_mdata m, logic expect_rsp);
        bus_if.c0_req_valid = v;
        bus_if.c0_req_addr  = a;
        bus_if.c0_req_mdata = m;
        if (v && expect_rsp) rd_q.push_back({m, mdl[a]});
    endtask

    task automatic set_wr(logic v, t_line_addr a, t_mdata m, t_line_data d);
        bus_if.c1_req_valid = v;
        bus_if.c1_req_addr  = a;
        bus_if.c1_req_mdata = m;
        bus_if.c1_req_data  = d;
        if (v) begin
            mdl[a] = d;
            wr_q.push_back(m);
        end
    endtask

    task automatic set_init(logic v, t_line_addr a, t_line_data d);
        init_en   = v;
        init_addr = a;
        init_data = d;
        if (v) mdl[a] = d;
    endtask

    task automatic preload(t_line_addr a, t_line_data d);
        set_init(1'b1, a, d);
        tick();
        set_init(1'b0, 8'd0, {DW{1'b0}});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_rd(1'b0, 8'd0, 16'd0, 1'b0);
        set_wr(1'b0, 8'd0, 16'd0, {DW{1'b0}});
        set_init(1'b0, 8'd0, {DW{1'b0}});
        tick();
        tick();
        reset = 1'b0;
        rd_q.delete();
        wr_q.delete();
    endtask

    task automatic drain(int n, string tag);
        repeat (n) tick();
        chkw({tag, "_rd_q_empty"}, DW'(rd_q.size()), DW'(0));
        chkw({tag, "_wr_q_empty"}, DW'(wr_q.size()), DW'(0));
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        set_rd(1'b0, 8'd0, 16'd0, 1'b0);
        set_wr(1'b0, 8'd0, 16'd0, {DW{1'b0}});
        set_init(1'b0, 8'd0, {DW{1'b0}});
        tick();
        tick();
        @(negedge clk);
        chkb("rst_c0_valid", bus_if.c0_rsp_valid, 1'b0);
        chkb("rst_c1_valid", bus_if.c1_rsp_valid, 1'b0);
        chkb("rst_c0_almfull", bus_if.c0_almfull, 1'b0);
        chkb("rst_c1_almfull", bus_if.c1_almfull, 1'b0);
        chkb("rst_overflow", overflow_err, 1'b0);
        chkw("rst_c0_mdata", DW'(bus_if.c0_rsp_mdata), DW'(0));
        chkw("rst_c1_mdata", DW'(bus_if.c1_rsp_mdata), DW'(0));
        chkw("rst_c0_data", bus_if.c0_rsp_data, {DW{1'b0}});
        tick();
        reset = 1'b0;

        // Preloaded single read: response exactly 3 cycles after issue
        preload(8'd5, 512'hDEAD);
        set_rd(1'b1, 8'd5, 16'h0012, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chkb($sformatf("rd_lat_c0_valid_T%0d", k), bus_if.c0_rsp_valid, (k == 3));
            if (k == 3) begin
                chkw("rd_lat_data", bus_if.c0_rsp_data, 512'hDEAD);
                chkw("rd_lat_mdata", DW'(bus_if.c0_rsp_mdata), DW'(16'h0012));
            end
            tick();
            if (k == 0) set_rd(1'b0, 8'd0, 16'd0, 1'b0);
        end
        drain(4, "rd_lat");

        // Write then read same line two cycles later
        set_wr(1'b1, 8'd3, 16'h0007, 512'hBEEF);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chkb($sformatf("wr_rd_c1_valid_T%0d", k), bus_if.c1_rsp_valid, (k == 2));
            chkb($sformatf("wr_rd_c0_valid_T%0d", k), bus_if.c0_rsp_valid, (k == 5));
            tick();
            if (k == 0) set_wr(1'b0, 8'd0, 16'd0, {DW{1'b0}});
            if (k == 1) set_rd(1'b1, 8'd3, 16'h0033, 1'b1);
            if (k == 2) set_rd(1'b0, 8'd0, 16'd0, 1'b0);
        end
        drain(4, "wr_rd");

        // Round robin, read first after reset: both responses on odd offsets T+3..T+13
        do_reset();
        for (int i = 0; i < 6; i++) preload(t_line_addr'(10 + i), pat(i));
        for (int k = 0; k < 16; k++) begin
            if (k < 6) begin
                set_rd(1'b1, t_line_addr'(10 + k), t_mdata'(16'h0100 + k), 1'b1);
                set_wr(1'b1, t_line_addr'(20 + k), t_mdata'(16'h0200 + k), pat(100 + k));
            end else begin
                set_rd(1'b0, 8'd0, 16'd0, 1'b0);
                set_wr(1'b0, 8'd0, 16'd0, {DW{1'b0}});
            end
            @(negedge clk);
            chkb($sformatf("rr_c0_valid_T%0d", k), bus_if.c0_rsp_valid, (k >= 3 && k <= 13 && (k % 2) == 1));
            chkb($sformatf("rr_c1_valid_T%0d", k), bus_if.c1_rsp_valid, (k >= 3 && k <= 13 && (k % 2) == 1));
            tick();
        end
        set_rd(1'b0, 8'd0, 16'd0, 1'b0);
        set_wr(1'b0, 8'd0, 16'd0, {DW{1'b0}});
        drain(4, "rr");

        // Seven reads while preload stalls the port: almfull from count 6, no overflow
        for (int k = 0; k < 9; k++) begin
            if (k < 8) set_init(1'b1, 8'd250, pat(200 + k));
            else set_init(1'b0, 8'd0, {DW{1'b0}});
            if (k < 7) set_rd(1'b1, t_line_addr'(10 + (k % 6)), t_mdata'(16'h0300 + k), 1'b1);
            else set_rd(1'b0, 8'd0, 16'd0, 1'b0);
            @(negedge clk);
            chkb($sformatf("af_c0_almfull_T%0d", k), bus_if.c0_almfull, (k >= 6));
            chkb($sformatf("af_c1_almfull_T%0d", k), bus_if.c1_almfull, 1'b0);
            chkb($sformatf("af_overflow_T%0d", k), overflow_err, 1'b0);
            tick();
        end
        set_init(1'b0, 8'd0, {DW{1'b0}});
        drain(25, "af");
        @(negedge clk);
        chkb("af_almfull_drained", bus_if.c0_almfull, 1'b0);
        tick();

        // Ten reads while stalled: first 8 kept, last 2 dropped, overflow sticky
        rsp_base = c0_rsp_cnt;
        for (int k = 0; k < 11; k++) begin
            set_init(1'b1, 8'd251, pat(300 + k));
            if (k < 10) set_rd(1'b1, t_line_addr'(10 + (k % 6)), t_mdata'(16'h0400 + k), (k < 8));
            else set_rd(1'b0, 8'd0, 16'd0, 1'b0);
            @(negedge clk);
            chkb($sformatf("ov_overflow_T%0d", k), overflow_err, (k >= 9));
            tick();
        end
        set_init(1'b0, 8'd0, {DW{1'b0}});
        drain(30, "ov");
        chkw("ov_rsp_count", DW'(c0_rsp_cnt - rsp_base), DW'(8));
        @(negedge clk);
        chkb("ov_overflow_sticky", overflow_err, 1'b1);
        tick();

        // Reset one cycle after a read issue: response cancelled, memory kept
        do_reset();
        @(negedge clk);
        chkb("rst_clears_overflow", overflow_err, 1'b0);
        tick();
        set_rd(1'b1, 8'd5, 16'h0055, 1'b0);
        tick();
        set_rd(1'b0, 8'd0, 16'd0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chkb($sformatf("mid_rst_c0_valid_T%0d", k), bus_if.c0_rsp_valid, 1'b0);
            chkb($sformatf("mid_rst_almfull_T%0d", k), bus_if.c0_almfull, 1'b0);
            tick();
        end
        set_rd(1'b1, 8'd5, 16'h0066, 1'b1);
        tick();
        set_rd(1'b0, 8'd0, 16'd0, 1'b0);
        drain(6, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
